uart_tx_arbiter: RTL

//  Shares the single UART TX line between NUM_REQ byte-stream sources (debug signal dump, ping reply, CPU console).

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_serializer.sv | 110 +++++++++++
 rtl/uart_tx_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: frame length, default baud
// divider, arbiter/serializer state encodings and a counter-width helper.
package uart_tx_arbiter_pkg;

    localparam int UART_LEN             = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_serializer.sv
// 8N1 UART serializer. Takes one byte per valid/ready handshake (ready only
// while idle), drives the start bit on the cycle after acceptance, sends data
// LSB first and holds every bit exactly CLKS_PER_BIT cycles. frame_done
// pulses on the last cycle of the stop bit.
module uart_tx_arbiter_serializer
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [UART_LEN-1:0] in_data,
    output logic                in_ready,
    output logic                uart_tx,
    output logic                idle,
    output logic                frame_done
);

    localparam int            CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [UART_LEN-1:0] shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic                cnt_last;

    assign cnt_last   = (cnt_q == CNT_LAST);
    assign in_ready   = (state_q == TX_IDLE);
    assign idle       = (state_q == TX_IDLE);
    assign frame_done = (state_q == TX_STOP) && cnt_last;
    assign uart_tx    = tx_q;

    // Serializer registers; the line is forced high the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // Bit timing and frame sequencing; tx_d is the line level for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                if (in_valid) begin
                    state_d = TX_START;
                    cnt_d   = '0;
                    shreg_d = in_data;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (cnt_last) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_last) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX line between
// NUM_REQ byte sources. A granted source keeps the line until the stop bit of
// its last byte has been sent; other requests never pre-empt it.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to end a packet whose owner
// stays silent for TIMEOUT_CYCLES idle cycles (abort pulses); otherwise abort
// is always 0 and an owner may stall indefinitely.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           src_valid,
    input  logic [NUM_REQ*UART_LEN-1:0]  src_data,
    input  logic [NUM_REQ-1:0]           src_last,
    output logic [NUM_REQ-1:0]           src_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         uart_tx,
    output logic                         busy,
    output logic                         abort
);

    localparam int              IDXW   = $clog2(NUM_REQ);
    localparam logic [IDXW:0]   NREQ_W = (IDXW + 1)'(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || CLKS_PER_BIT < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("uart_tx_arbiter: parameter out of range");
        end
    endgenerate

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]     own_q, own_d, rr_q, rr_d, pick_idx, own_next;
    logic                last_q, last_d, abort_q, abort_d;
    logic [NUM_REQ-1:0]  rot_valid;
    logic [IDXW:0]       pick_sum;
    logic                pick_found;
    logic                sel_valid, sel_last;
    logic [UART_LEN-1:0] sel_data;
    logic                ser_valid, ser_ready, ser_idle, ser_done, accept, tmo_hit;

    // Round-robin search: rotate requests so the rr pointer sits at bit 0,
    // take the lowest set bit, then rotate the index back.
    always_comb begin
        rot_valid  = NUM_REQ'({src_valid, src_valid} >> rr_q);
        pick_found = 1'b0;
        pick_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_q} + (IDXW + 1)'(k);
            end
        end
        if (pick_sum >= NREQ_W) begin
            pick_sum = pick_sum - NREQ_W;
        end
        pick_idx = pick_sum[IDXW-1:0];
    end

    // Steer the owner's byte, valid and last flag towards the serializer.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (own_q == IDXW'(k)) begin
                sel_valid = src_valid[k];
                sel_last  = src_last[k];
                sel_data  = src_data[k*UART_LEN +: UART_LEN];
            end
        end
    end

    assign own_next  = (own_q == IDXW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
    assign ser_valid = (state_q == ARB_OWN) && sel_valid;
    assign accept    = ser_valid && ser_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign src_ready[gi] = (state_q == ARB_OWN) && grant_q[gi] && src_valid[gi] && ser_ready;
        end
    endgenerate

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          owner_silent;

    assign owner_silent = (state_q == ARB_OWN) && ser_idle && !sel_valid;
    assign tmo_hit      = owner_silent && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Count consecutive idle-line cycles in which the owner offers nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // Any activity, or leaving ARB_OWN, restarts the silence count.
    always_comb begin
        tmo_d = '0;
        if (owner_silent) begin
            tmo_d = tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            own_q   <= '0;
            rr_q    <= '0;
            last_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            abort_q <= abort_d;
        end
    end

    // Grant on request, remember a last byte, release after its stop bit (or on timeout).
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        rr_d    = rr_q;
        last_d  = last_q;
        abort_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_OWN;
                    own_d   = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    last_d  = 1'b0;
                end
            end
            ARB_OWN: begin
                if (accept) begin
                    last_d = sel_last;
                end
                if ((ser_done && last_q) || tmo_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    last_d  = 1'b0;
                    rr_d    = own_next;
                    abort_d = tmo_hit;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    uart_tx_arbiter_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (ser_valid),
        .in_data    (sel_data),
        .in_ready   (ser_ready),
        .uart_tx    (uart_tx),
        .idle       (ser_idle),
        .frame_done (ser_done)
    );

    assign grant = grant_q;
    assign busy  = (grant_q != '0) || !ser_idle;
    assign abort = abort_q;

endmodule
